// File: rtl/jtpopeye_dwnld_mux.sv
// jtpopeye_dwnld_mux
//   Splits the ioctl ROM download byte stream into two targets:
//     - bytes below SDRAM_END are queued in a 2-entry FIFO and written to
//       SDRAM as masked 16-bit words through a req/ack handshake;
//     - bytes from SDRAM_END upward land in one of PROM_CNT PROM windows of
//       2^PROM_AW bytes each, strobed one cycle after they are accepted.
//   Also raises a sticky overflow flag and pulses dwn_done once the SDRAM
//   queue has drained after the download session ends.
//
// Optional feature: define JTPOPEYE_DWNLD_CHECKSUM_EN to add checksum_o, a
// 16-bit wrapping sum of the bytes accepted in the current session.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   downloading_i       download session active
//   ioctl_addr_i/data_i byte address and data; ioctl_wr_i one-cycle strobe
//   ioctl_wait_o        back-pressure, high while the SDRAM FIFO is full
//   prog_*_o            SDRAM word request (mask active-low); prog_ack_i accept
//   prom_addr/data/we_o PROM write port, prom_we_o one-hot
//   dwn_done_o          end-of-session pulse
//   overflow_o          sticky: a byte arrived while ioctl_wait_o was high
//   checksum_o          running byte sum (checksum build only)
`timescale 1ns / 1ps

module jtpopeye_dwnld_mux #(
    parameter int unsigned AW        = 22,
    parameter int unsigned SDRAM_END = 32768,
    parameter int unsigned PROM_CNT  = 14,
    parameter int unsigned PROM_AW   = 13
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                downloading_i,
    input  logic [AW-1:0]       ioctl_addr_i,
    input  logic [7:0]          ioctl_data_i,
    input  logic                ioctl_wr_i,
    output logic                ioctl_wait_o,
    output logic [AW-2:0]       prog_addr_o,
    output logic [15:0]         prog_data_o,
    output logic [1:0]          prog_mask_o,
    output logic                prog_we_o,
    input  logic                prog_ack_i,
    output logic [PROM_AW-1:0]  prom_addr_o,
    output logic [7:0]          prom_data_o,
    output logic [PROM_CNT-1:0] prom_we_o,
    output logic                dwn_done_o,
    output logic                overflow_o
`ifdef JTPOPEYE_DWNLD_CHECKSUM_EN
    ,
    output logic [15:0]         checksum_o
`endif
);

    // FIFO entry: {word address, byte, byte select}
    localparam int unsigned EW = AW + 8;

    typedef enum logic {StIdle, StReq} prog_st_e;
    typedef enum logic {SessRun, SessDrain} sess_st_e;

    prog_st_e prog_st_q, prog_st_d;
    sess_st_e sess_st_q, sess_st_d;

    logic [EW-1:0] fifo_q [2];
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    cnt_q, cnt_d;
    logic          dl_q;
    logic          overflow_q, overflow_d;

    logic [PROM_CNT-1:0] prom_we_q, prom_we_d;
    logic [PROM_AW-1:0]  prom_addr_q;
    logic [7:0]          prom_data_q;

    logic          accept, is_sdram, push, pop, prom_hit;
    logic          dl_rise, dl_fall;
    logic [AW-1:0] prom_off, prom_idx;
    logic [EW-1:0] head;

    // ------------------------------------------------------------------
    // Input decode
    // ------------------------------------------------------------------
    assign ioctl_wait_o = (cnt_q == 2'd2);
    assign accept       = ioctl_wr_i & ~ioctl_wait_o;
    assign is_sdram     = ioctl_addr_i < AW'(SDRAM_END);
    assign prom_off     = ioctl_addr_i - AW'(SDRAM_END);
    assign prom_idx     = prom_off >> PROM_AW;
    assign prom_hit     = ~is_sdram & (prom_idx < AW'(PROM_CNT));
    assign push         = accept & is_sdram;
    // An ack is only meaningful while a request is outstanding
    assign pop          = prog_ack_i & prog_we_o;
    assign dl_rise      = downloading_i & ~dl_q;
    assign dl_fall      = ~downloading_i & dl_q;

    // ------------------------------------------------------------------
    // SDRAM FIFO and request FSM
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Request stays up whenever the FIFO holds data, so prog_we rises the
    // cycle after a push into an empty FIFO and back-to-back entries issue
    // without a gap.
    always_comb begin
        prog_st_d = prog_st_q;
        unique case (prog_st_q)
            StIdle:  if (cnt_d != 2'd0) prog_st_d = StReq;
            StReq:   if (cnt_d == 2'd0) prog_st_d = StIdle;
            default: prog_st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
            prog_st_q <= StIdle;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= {ioctl_addr_i[AW-1:1], ioctl_data_i, ioctl_addr_i[0]};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q     <= cnt_d;
            prog_st_q <= prog_st_d;
        end
    end

    // Head fields come straight from flops; they only move on a pop, so they
    // are stable while prog_we_o waits for its ack. Idle value matches reset.
    assign head = fifo_q[rd_ptr_q];

    always_comb begin
        prog_we_o   = (prog_st_q == StReq);
        prog_addr_o = '0;
        prog_data_o = '0;
        prog_mask_o = 2'b11;
        if (prog_we_o) begin
            prog_addr_o = head[EW-1:9];
            prog_data_o = {head[8:1], head[8:1]};
            // Even byte is the upper half of the word: enable it (active-low)
            prog_mask_o = {head[0], ~head[0]};
        end
    end

    // ------------------------------------------------------------------
    // PROM writes
    // ------------------------------------------------------------------
    always_comb begin
        prom_we_d = '0;
        for (int unsigned i = 0; i < PROM_CNT; i++) begin
            if (accept && prom_hit && (prom_idx == AW'(i))) prom_we_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prom_we_q   <= '0;
            prom_addr_q <= '0;
            prom_data_q <= '0;
        end else begin
            prom_we_q <= prom_we_d;
            if (accept && prom_hit) begin
                prom_addr_q <= prom_off[PROM_AW-1:0];
                prom_data_q <= ioctl_data_i;
            end
        end
    end

    assign prom_we_o   = prom_we_q;
    assign prom_addr_o = prom_addr_q;
    assign prom_data_o = prom_data_q;

    // ------------------------------------------------------------------
    // Session tracking: drain, done pulse, overflow
    // ------------------------------------------------------------------
    always_comb begin
        sess_st_d  = sess_st_q;
        dwn_done_o = 1'b0;
        unique case (sess_st_q)
            SessRun: if (dl_fall) sess_st_d = SessDrain;
            SessDrain: begin
                // A new session arriving before the drain finishes cancels it
                if (downloading_i) begin
                    sess_st_d = SessRun;
                end else if ((cnt_q == 2'd0) && !prog_we_o) begin
                    dwn_done_o = 1'b1;
                    sess_st_d  = SessRun;
                end
            end
            default: sess_st_d = SessRun;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (dl_rise) overflow_d = 1'b0;
        if (ioctl_wr_i && ioctl_wait_o) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sess_st_q  <= SessRun;
            dl_q       <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            sess_st_q  <= sess_st_d;
            dl_q       <= downloading_i;
            overflow_q <= overflow_d;
        end
    end

    assign overflow_o = overflow_q;

`ifdef JTPOPEYE_DWNLD_CHECKSUM_EN
    // ------------------------------------------------------------------
    // Session checksum
    // ------------------------------------------------------------------
    logic [15:0] csum_q, csum_d;

    always_comb begin
        csum_d = dl_rise ? 16'd0 : csum_q;
        if (accept) csum_d = csum_d + {8'd0, ioctl_data_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) csum_q <= 16'd0;
        else        csum_q <= csum_d;
    end

    assign checksum_o = csum_q;
`endif

endmodule

// File: tb/tb_jtpopeye_dwnld_mux.sv
`timescale 1ns / 1ps

module tb_jtpopeye_dwnld_mux;

    localparam int unsigned AW = 22;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          downloading;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_data;
    logic          ioctl_wr;
    logic          ioctl_wait;
    logic [AW-2:0] prog_addr;
    logic [15:0]   prog_data;
    logic [1:0]    prog_mask;
    logic          prog_we;
    logic          prog_ack;
    logic [12:0]   prom_addr;
    logic [7:0]    prom_data;
    logic [13:0]   prom_we;
    logic          dwn_done;
    logic          overflow;
`ifdef JTPOPEYE_DWNLD_CHECKSUM_EN
    logic [15:0]   checksum;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    jtpopeye_dwnld_mux u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .downloading_i(downloading),
        .ioctl_addr_i (ioctl_addr),
        .ioctl_data_i (ioctl_data),
        .ioctl_wr_i   (ioctl_wr),
        .ioctl_wait_o (ioctl_wait),
        .prog_addr_o  (prog_addr),
        .prog_data_o  (prog_data),
        .prog_mask_o  (prog_mask),
        .prog_we_o    (prog_we),
        .prog_ack_i   (prog_ack),
        .prom_addr_o  (prom_addr),
        .prom_data_o  (prom_data),
        .prom_we_o    (prom_we),
        .dwn_done_o   (dwn_done),
        .overflow_o   (overflow)
`ifdef JTPOPEYE_DWNLD_CHECKSUM_EN
        ,
        .checksum_o   (checksum)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One-cycle byte strobe; returns 1ns after the edge that sampled it
    task automatic send_byte(input logic [AW-1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_data = d;
        @(posedge clk); #1;
        ioctl_wr   = 1'b0;
    endtask

    // Wait (bounded) for a request, check it, then ack it for one cycle
    task automatic expect_word(input string tag, input logic [AW-2:0] a,
                               input logic [15:0] d, input logic [1:0] m);
        @(negedge clk);
        for (int i = 0; i < 20 && !prog_we; i++) @(negedge clk);
        check({tag, "_we"}, 32'(prog_we), 32'd1);
        check({tag, "_addr"}, 32'(prog_addr), 32'(a));
        check({tag, "_data"}, 32'(prog_data), 32'(d));
        check({tag, "_mask"}, 32'(prog_mask), 32'(m));
        @(posedge clk); #1 prog_ack = 1'b1;
        @(posedge clk); #1 prog_ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] drain_data [2];
        logic [1:0]  drain_mask [2];
        drain_data[0] = 16'h5555; drain_mask[0] = 2'b01;
        drain_data[1] = 16'h6666; drain_mask[1] = 2'b10;

        rst_n = 1'b0; downloading = 1'b0; ioctl_addr = '0; ioctl_data = '0;
        ioctl_wr = 1'b0; prog_ack = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_prog_we", 32'(prog_we), 32'd0);
        check("rst_prog_mask", 32'(prog_mask), 32'd3);
        check("rst_prog_addr", 32'(prog_addr), 32'd0);
        check("rst_prog_data", 32'(prog_data), 32'd0);
        check("rst_wait", 32'(ioctl_wait), 32'd0);
        check("rst_prom_we", 32'(prom_we), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_done", 32'(dwn_done), 32'd0);
`ifdef JTPOPEYE_DWNLD_CHECKSUM_EN
        check("rst_checksum", 32'(checksum), 32'd0);
`endif
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 downloading = 1'b1;

        // Two bytes of one word, prompt acks
        send_byte(22'd0, 8'h12);
        @(negedge clk);
        check("w0_latency", 32'(prog_we), 32'd1);
        expect_word("w0", 21'd0, 16'h1212, 2'b01);
        @(negedge clk);
        check("w0_we_low", 32'(prog_we), 32'd0);
        send_byte(22'd1, 8'h34);
        expect_word("w1", 21'd0, 16'h3434, 2'b10);
        @(negedge clk);
        check("w1_we_low", 32'(prog_we), 32'd0);
        check("w1_overflow", 32'(overflow), 32'd0);

        // Back-pressure: three back-to-back bytes, no acks for 10 cycles
        @(posedge clk); #1;
        ioctl_wr = 1'b1; ioctl_addr = 22'd4; ioctl_data = 8'hA1;
        @(posedge clk); #1;
        ioctl_addr = 22'd5; ioctl_data = 8'hA2;
        @(posedge clk); #1;
        ioctl_addr = 22'd6; ioctl_data = 8'hA3;
        @(negedge clk);
        check("bp_wait", 32'(ioctl_wait), 32'd1);
        @(posedge clk); #1 ioctl_wr = 1'b0;
        @(negedge clk);
        check("bp_overflow", 32'(overflow), 32'd1);
        repeat (10) @(negedge clk);
        check("bp_hold_we", 32'(prog_we), 32'd1);
        check("bp_hold_data", 32'(prog_data), 32'hA1A1);
        expect_word("bp0", 21'd2, 16'hA1A1, 2'b01);
        expect_word("bp1", 21'd2, 16'hA2A2, 2'b10);
        repeat (3) @(negedge clk);
        check("bp_no_third", 32'(prog_we), 32'd0);
        check("bp_wait_low", 32'(ioctl_wait), 32'd0);

        // PROM window 3, offset 5
        send_byte(22'(32768 + 3 * 8192 + 5), 8'hA5);
        @(negedge clk);
        check("prom3_we", 32'(prom_we), 32'h0008);
        check("prom3_addr", 32'(prom_addr), 32'd5);
        check("prom3_data", 32'(prom_data), 32'hA5);
        check("prom3_no_sdram", 32'(prog_we), 32'd0);
        @(negedge clk);
        check("prom3_single", 32'(prom_we), 32'd0);
        // Past the last window: dropped
        send_byte(22'(32768 + 14 * 8192), 8'h5A);
        @(negedge clk);
        check("prom_oob_we", 32'(prom_we), 32'd0);
        @(negedge clk);
        check("prom_oob_we2", 32'(prom_we), 32'd0);
        check("prom_oob_ovf", 32'(overflow), 32'd1);
        // Window edges
        send_byte(22'd32768, 8'h3C);
        @(negedge clk);
        check("prom0_we", 32'(prom_we), 32'h0001);
        check("prom0_addr", 32'(prom_addr), 32'd0);
        send_byte(22'(32768 + 13 * 8192 + 8191), 8'hE7);
        @(negedge clk);
        check("prom13_we", 32'(prom_we), 32'h2000);
        check("prom13_addr", 32'(prom_addr), 32'h1FFF);
        check("prom13_data", 32'(prom_data), 32'hE7);
        send_byte(22'd32767, 8'hC3);
        expect_word("sdram_top", 21'd16383, 16'hC3C3, 2'b10);

        // Drain: two entries queued, session ends, acks 4 cycles apart
        @(posedge clk); #1;
        ioctl_wr = 1'b1; ioctl_addr = 22'd8; ioctl_data = 8'h55;
        @(posedge clk); #1;
        ioctl_addr = 22'd9; ioctl_data = 8'h66;
        @(posedge clk); #1;
        ioctl_wr = 1'b0; downloading = 1'b0;
        for (int k = 0; k < 2; k++) begin
            repeat (4) begin
                @(negedge clk);
                check("drain_early_done", 32'(dwn_done), 32'd0);
            end
            check("drain_we", 32'(prog_we), 32'd1);
            check("drain_data", 32'(prog_data), 32'(drain_data[k]));
            check("drain_mask", 32'(prog_mask), 32'(drain_mask[k]));
            @(posedge clk); #1 prog_ack = 1'b1;
            @(posedge clk); #1 prog_ack = 1'b0;
            @(negedge clk);
            check("drain_done", 32'(dwn_done), (k == 1) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("drain_done_once", 32'(dwn_done), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // New session clears overflow
        @(posedge clk); #1 downloading = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Drain aborted by a new session: no done pulse
        send_byte(22'd20, 8'h99);
        @(posedge clk); #1 downloading = 1'b0;
        @(negedge clk);
        check("abort_done0", 32'(dwn_done), 32'd0);
        @(posedge clk); #1 downloading = 1'b1;
        @(negedge clk);
        check("abort_done1", 32'(dwn_done), 32'd0);
        expect_word("abort", 21'd10, 16'h9999, 2'b01);
        repeat (3) begin
            @(negedge clk);
            check("abort_done2", 32'(dwn_done), 32'd0);
        end

        // Reset while a request is pending
        send_byte(22'd10, 8'h77);
        @(negedge clk);
        check("mid_we", 32'(prog_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_we", 32'(prog_we), 32'd0);
        check("mid_rst_mask", 32'(prog_mask), 32'd3);
        check("mid_rst_wait", 32'(ioctl_wait), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("post_rst_we", 32'(prog_we), 32'd0);
        end
        send_byte(22'd12, 8'h88);
        expect_word("post_rst", 21'd6, 16'h8888, 2'b01);

`ifdef JTPOPEYE_DWNLD_CHECKSUM_EN
        @(posedge clk); #1 downloading = 1'b0;
        @(posedge clk); #1 downloading = 1'b1;
        @(posedge clk);
        send_byte(22'd32768, 8'hFF);
        send_byte(22'd32769, 8'hFF);
        send_byte(22'd32770, 8'h03);
        @(negedge clk);
        check("csum_sum", 32'(checksum), 32'h0201);
        @(posedge clk); #1 downloading = 1'b0;
        repeat (2) @(negedge clk);
        check("csum_held", 32'(checksum), 32'h0201);
        @(posedge clk); #1 downloading = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("csum_clear", 32'(checksum), 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
